// File: rtl/fir_pkg.sv
// Shared widths, FSM state encoding, coefficient reset table and output
// saturation for the time-multiplexed FIR.
package fir_pkg;

  localparam int TAPS_DEF = 4;
  localparam int DW_DEF   = 8;
  localparam int CW_DEF   = 8;
  localparam int OW_DEF   = 16;
  localparam int ACCW_DEF = DW_DEF + CW_DEF + $clog2(TAPS_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Power-up coefficient for tap k: 1, 2, 3, ...
  function automatic int coef_reset(input int k);
    return k + 1;
  endfunction

  // Clamp a sign-extended value into the signed range of an ow-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered signed multiply-accumulate: clr zeroes, en adds the full-precision
// product a*b sign-extended to the accumulator width.
module fir_mac_unit #(
  parameter int AW   = 8,
  parameter int BW   = 8,
  parameter int ACCW = 18
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [AW-1:0]   a,
  input  logic signed [BW-1:0]   b,
  output logic signed [ACCW-1:0] acc
);

  logic signed [AW+BW-1:0] prod;
  logic signed [ACCW-1:0]  acc_q;
  logic signed [ACCW-1:0]  acc_d;

  assign prod  = a * b;
  assign acc_d = acc_q + ACCW'(prod);
  assign acc   = acc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      acc_q <= '0;
    else if (clr)
      acc_q <= '0;
    else if (en)
      acc_q <= acc_d;
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequences one shared MAC over all taps per accepted sample; owns the circular
// sample history, the writable coefficient bank and both valid/ready handshakes.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF,
  parameter int OW   = OW_DEF,
  parameter int ACCW = DW + CW + $clog2(TAPS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DW-1:0]      x_data,
  input  logic                      clear_hist,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [CW-1:0]      coef_data,
  output logic                      coef_busy,
  output logic                      coef_err,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OW-1:0]      y_data
);

  localparam int PW = $clog2(TAPS);

  state_t               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 coef_busy_q;
  logic                 coef_err_q;
  logic [PW-1:0]        newest_q;
  logic [PW-1:0]        k_q;

  logic                 idle;
  logic                 accept;
  logic                 last_tap;
  logic [PW-1:0]        wr_idx;
  logic [PW-1:0]        rd_idx;
  logic signed [DW-1:0] hist [TAPS];
  logic signed [CW-1:0] coef [TAPS];
  logic signed [ACCW-1:0] acc;

  assign idle     = (state_q == ST_IDLE);
  assign accept   = idle && in_ready_q && in_valid;
  assign wr_idx   = newest_q + PW'(1);
  // Power-of-two depth: plain subtraction wraps modulo TAPS.
  assign rd_idx   = newest_q - k_q;
  assign last_tap = (k_q == PW'(TAPS - 1));

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      logic signed [DW-1:0] hist_q;
      logic signed [CW-1:0] coef_q;

      // The accepted sample wins over a same-cycle clear of its own slot.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          hist_q <= '0;
          coef_q <= CW'(coef_reset(gi));
        end else begin
          if (accept && (wr_idx == PW'(gi)))
            hist_q <= x_data;
          else if (idle && clear_hist)
            hist_q <= '0;
          if (idle && coef_we && (coef_addr == PW'(gi)))
            coef_q <= coef_data;
        end
      end

      assign hist[gi] = hist_q;
      assign coef[gi] = coef_q;
    end
  endgenerate

  fir_mac_unit #(
    .AW   (CW),
    .BW   (DW),
    .ACCW (ACCW)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (state_q == ST_MAC),
    .a     (coef[k_q]),
    .b     (hist[rd_idx]),
    .acc   (acc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      coef_busy_q <= 1'b0;
      coef_err_q  <= 1'b0;
      newest_q    <= PW'(TAPS - 1);
      k_q         <= '0;
    end else begin
      if (coef_we && coef_busy_q)
        coef_err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            newest_q    <= wr_idx;
            k_q         <= '0;
            in_ready_q  <= 1'b0;
            coef_busy_q <= 1'b1;
            state_q     <= ST_MAC;
          end else begin
            in_ready_q  <= 1'b1;
          end
        end
        ST_MAC: begin
          k_q <= k_q + PW'(1);
          if (last_tap) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            coef_busy_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // acc is frozen while OUT waits, so the saturated result holds under backpressure.
  assign y_data    = OW'(saturate(64'(acc), OW));
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign coef_busy = coef_busy_q;
  assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Randomised self-checking bench for fir_mac_sequencer against a shift-register
// convolution model of the filter.
module tb_fir_mac_sequencer;

  localparam int TAPS = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [7:0]  x_data = '0;
  logic               clear_hist = 1'b0;
  logic               coef_we = 1'b0;
  logic [1:0]         coef_addr = '0;
  logic signed [7:0]  coef_data = '0;
  logic               coef_busy;
  logic               coef_err;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] y_data;

  fir_mac_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x_data     (x_data),
    .clear_hist (clear_hist),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_busy  (coef_busy),
    .coef_err   (coef_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y_data     (y_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: h_m[k] coefficients, x_m[k] = x[n-k] (x_m[0] newest sample).
  int h_m [TAPS];
  int x_m [TAPS];

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int model_y();
    int s = 0;
    for (int k = 0; k < TAPS; k++) s += h_m[k] * x_m[k];
    return sat16(s);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      h_m[k] = k + 1;
      x_m[k] = 0;
    end
  endtask

  task automatic model_accept(input int x, input bit clr);
    if (clr) for (int k = 0; k < TAPS; k++) x_m[k] = 0;
    for (int k = TAPS - 1; k > 0; k--) x_m[k] = x_m[k-1];
    x_m[0] = x;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; clear_hist = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  // Caller guarantees the DUT is idle; called 1 time unit after a rising edge.
  task automatic write_coef(input int a, input int d);
    coef_we = 1'b1; coef_addr = 2'(a); coef_data = 8'(d);
    @(posedge clk); #1 coef_we = 1'b0;
    h_m[a] = d;
  endtask

  // Offers one sample (optionally with clear and a same-cycle coefficient
  // write), waits for the result and consumes it if out_ready is high.
  // lat counts the accept cycle as cycle 1; y = -99999 and lat = -1 on timeout.
  task automatic run_sample(input int x, input bit clr, input bit we,
                            input int wa, input int wd,
                            output int y, output int lat, output int acc_cyc);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1 t++;
    end
    in_valid = 1'b1; x_data = 8'(x); clear_hist = clr;
    coef_we = we; coef_addr = 2'(wa); coef_data = 8'(wd);
    @(posedge clk); #1;
    in_valid = 1'b0; clear_hist = 1'b0; coef_we = 1'b0;
    acc_cyc = cyc;
    if (we) h_m[wa] = wd;
    model_accept(x, clr);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1 lat++;
    end
    if (out_valid) y = int'(y_data);
    else begin y = -99999; lat = -1; end
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (y_data !== 16'sd0) begin n_fail++; $display("FAIL reset_y_data got=%0d exp=0", y_data); end
    n_tests++; if (coef_busy !== 1'b0) begin n_fail++; $display("FAIL reset_coef_busy got=%b exp=0", coef_busy); end
    n_tests++; if (coef_err !== 1'b0) begin n_fail++; $display("FAIL reset_coef_err got=%b exp=0", coef_err); end
    @(posedge clk); #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_rise got=%b exp=1", in_ready); end
  endtask

  task automatic test_impulse();
    int xs [5] = '{1, 0, 0, 0, 0};
    int ey [5] = '{1, 2, 3, 4, 0};
    int y, lat, ac;
    for (int i = 0; i < 5; i++) begin
      run_sample(xs[i], 1'b0, 1'b0, 0, 0, y, lat, ac);
      n_tests++; if (y !== ey[i]) begin n_fail++; $display("FAIL impulse_y[%0d] got=%0d exp=%0d", i, y, ey[i]); end
      $display("[TB] impulse x=%0d y=%0d lat=%0d", xs[i], y, lat);
    end
  endtask

  task automatic test_back_to_back();
    int y, lat, ac, prev_ac;
    prev_ac = 0;
    for (int i = 0; i < 6; i++) begin
      int x = int'($urandom_range(0, 255)) - 128;
      run_sample(x, 1'b0, 1'b0, 0, 0, y, lat, ac);
      n_tests++; if (y !== model_y()) begin n_fail++; $display("FAIL b2b_y[%0d] got=%0d exp=%0d", i, y, model_y()); end
      n_tests++; if (lat !== TAPS + 1) begin n_fail++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, lat, TAPS + 1); end
      if (i > 0) begin
        n_tests++; if (ac - prev_ac !== TAPS + 2) begin n_fail++; $display("FAIL b2b_period[%0d] got=%0d exp=%0d", i, ac - prev_ac, TAPS + 2); end
      end
      $display("[TB] b2b x=%0d y=%0d lat=%0d accept_cyc=%0d", x, y, lat, ac);
      prev_ac = ac;
    end
  endtask

  task automatic test_random();
    int y, lat, ac;
    for (int i = 0; i < 30; i++) begin
      int  x  = int'($urandom_range(0, 255)) - 128;
      bit  we = ($urandom_range(0, 3) == 0);
      bit  cl = ($urandom_range(0, 7) == 0);
      int  wa = int'($urandom_range(0, TAPS - 1));
      int  wd = int'($urandom_range(0, 255)) - 128;
      run_sample(x, cl, we, wa, wd, y, lat, ac);
      n_tests++; if (y !== model_y()) begin n_fail++; $display("FAIL random_y[%0d] got=%0d exp=%0d", i, y, model_y()); end
      $display("[TB] random x=%0d clr=%0d we=%0d h[%0d]=%0d y=%0d", x, cl, we, wa, wd, y);
    end
  endtask

  task automatic test_backpressure();
    int y, y0, lat, ac;
    int x = int'($urandom_range(0, 255)) - 128;
    out_ready = 1'b0;
    run_sample(x, 1'b0, 1'b0, 0, 0, y0, lat, ac);
    n_tests++; if (y0 !== model_y()) begin n_fail++; $display("FAIL bp_y got=%0d exp=%0d", y0, model_y()); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid, in_ready, y_data} !== {1'b1, 1'b0, 16'(y0)}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got v=%b r=%b y=%0d exp v=1 r=0 y=%0d", i, out_valid, in_ready, y_data, y0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got=%b exp=0", out_valid); end
    x = int'($urandom_range(0, 255)) - 128;
    run_sample(x, 1'b0, 1'b0, 0, 0, y, lat, ac);
    n_tests++; if (y !== model_y()) begin n_fail++; $display("FAIL bp_next_y got=%0d exp=%0d", y, model_y()); end
    $display("[TB] backpressure held_y=%0d next_y=%0d", y0, y);
  endtask

  task automatic test_saturation();
    int y, lat, ac;
    for (int k = 0; k < TAPS; k++) write_coef(k, 127);
    for (int i = 0; i < 4; i++) begin
      run_sample(127, 1'b0, 1'b0, 0, 0, y, lat, ac);
      n_tests++; if (y !== model_y()) begin n_fail++; $display("FAIL sat_pos_y[%0d] got=%0d exp=%0d", i, y, model_y()); end
    end
    n_tests++; if (y !== 32767) begin n_fail++; $display("FAIL sat_pos_final got=%0d exp=32767", y); end
    $display("[TB] saturation positive y=%0d", y);
    for (int i = 0; i < 4; i++) begin
      run_sample(-128, 1'b0, 1'b0, 0, 0, y, lat, ac);
      n_tests++; if (y !== model_y()) begin n_fail++; $display("FAIL sat_neg_y[%0d] got=%0d exp=%0d", i, y, model_y()); end
    end
    n_tests++; if (y !== -32768) begin n_fail++; $display("FAIL sat_neg_final got=%0d exp=-32768", y); end
    $display("[TB] saturation negative y=%0d", y);
  endtask

  task automatic test_coef_clear();
    int y, lat, ac, t;
    int x;
    apply_reset();
    @(posedge clk); #1;
    write_coef(2, -5);
    for (int i = 0; i < 4; i++) begin
      x = int'($urandom_range(0, 255)) - 128;
      run_sample(x, 1'b0, 1'b0, 0, 0, y, lat, ac);
      n_tests++; if (y !== model_y()) begin n_fail++; $display("FAIL coef_h2_y[%0d] got=%0d exp=%0d", i, y, model_y()); end
      $display("[TB] coef h2=-5 x=%0d y=%0d", x, y);
    end
    // Write attempted two cycles into MAC must be dropped and flagged.
    x = int'($urandom_range(1, 100));
    in_valid = 1'b1; x_data = 8'(x);
    @(posedge clk); #1 in_valid = 1'b0;
    model_accept(x, 1'b0);
    @(posedge clk); #1;
    n_tests++; if (coef_busy !== 1'b1) begin n_fail++; $display("FAIL mac_coef_busy got=%b exp=1", coef_busy); end
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'sd50;
    @(posedge clk); #1 coef_we = 1'b0;
    n_tests++; if (coef_err !== 1'b1) begin n_fail++; $display("FAIL mac_coef_err got=%b exp=1", coef_err); end
    t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); #1 t++; end
    n_tests++; if (int'(y_data) !== model_y() || !out_valid) begin n_fail++; $display("FAIL mac_drop_y got=%0d valid=%b exp=%0d", y_data, out_valid, model_y()); end
    $display("[TB] dropped write x=%0d y=%0d", x, y_data);
    @(posedge clk); #1;
    run_sample(7, 1'b1, 1'b0, 0, 0, y, lat, ac);
    n_tests++; if (y !== 7) begin n_fail++; $display("FAIL clear_hist_y got=%0d exp=7", y); end
    n_tests++; if (coef_err !== 1'b1) begin n_fail++; $display("FAIL coef_err_sticky got=%b exp=1", coef_err); end
    $display("[TB] clear_hist+7 y=%0d", y);
  endtask

  task automatic test_reset_mid_mac();
    int y, lat, ac;
    bit seen;
    int ey [4] = '{1, 2, 3, 4};
    int xs [4] = '{1, 0, 0, 0};
    in_valid = 1'b1; x_data = 8'sd55;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    #1;
    n_tests++; if ({out_valid, in_ready} !== 2'b00) begin n_fail++; $display("FAIL midrst_async got v=%b r=%b exp 0 0", out_valid, in_ready); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b exp=0", seen); end
    n_tests++; if (coef_err !== 1'b0) begin n_fail++; $display("FAIL midrst_coef_err got=%b exp=0", coef_err); end
    for (int i = 0; i < 4; i++) begin
      run_sample(xs[i], 1'b0, 1'b0, 0, 0, y, lat, ac);
      n_tests++; if (y !== ey[i]) begin n_fail++; $display("FAIL midrst_impulse[%0d] got=%0d exp=%0d", i, y, ey[i]); end
      $display("[TB] post-reset impulse x=%0d y=%0d", xs[i], y);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_impulse();
    test_back_to_back();
    test_random();
    test_backpressure();
    test_saturation();
    test_coef_clear();
    test_reset_mid_mac();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
